// File: rtl/alu_mult_seq.sv
// Sequential radix-2 shift-add unsigned multiplier (IDLE/RUN/DONE) with optional high half (ALU_MULT_HI_EN).
// Latency: start at edge N -> busy for WIDTH cycles, done pulse in the cycle after edge N+WIDTH.
// Backpressure: start is ignored while busy; accepted in IDLE or DONE (back-to-back); reset aborts.
module alu_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
`ifdef ALU_MULT_HI_EN
    ,
    output logic [WIDTH-1:0] product_hi
`endif
);

`ifdef ALU_MULT_HI_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    // Without the high half only the low WIDTH bits of the sum are ever observed.
    localparam int ACC_W = WIDTH;
`endif
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   mcand_q;    // multiplicand, held wide so the shifted addend never truncates
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   addend;
    logic [WIDTH-1:0]   mplier_q;   // multiplier, consumed LSB first
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   prod_lo_q;
`ifdef ALU_MULT_HI_EN
    logic [WIDTH-1:0]   prod_hi_q;
`endif
    logic               last_bit;
    logic               accept;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q != S_RUN) && start;

    // One shift-add step: add the multiplicand weighted by the current bit position.
    always_comb begin
        addend = mcand_q << cnt_q;
        acc_d  = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + addend;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start during RUN is deliberately not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded straight from the registered state.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Datapath: capture on accept, iterate in RUN, publish the product on the final step only.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            prod_lo_q <= '0;
`ifdef ALU_MULT_HI_EN
            prod_hi_q <= '0;
`endif
        end else if (accept) begin
            mcand_q  <= ACC_W'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == S_RUN) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                prod_lo_q <= acc_d[WIDTH-1:0];
`ifdef ALU_MULT_HI_EN
                prod_hi_q <= acc_d[2*WIDTH-1:WIDTH];
`endif
            end
        end
    end

    assign product = prod_lo_q;
`ifdef ALU_MULT_HI_EN
    assign product_hi = prod_hi_q;
`endif

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a cycle-level reference model and literal spot checks.
// Inputs change 1 time unit after the rising edge; the model advances on the rising edge.
// DUT outputs are compared against the model on every falling edge once reset has been seen.
module tb_alu_mult_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] product;
`ifdef ALU_MULT_HI_EN
    logic [W-1:0] product_hi;
`endif

    int errors = 0;
    int checks = 0;
    int busy_seen = 0;
    int done_seen = 0;

    alu_mult_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
`ifdef ALU_MULT_HI_EN
        ,
        .product_hi (product_hi)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a multiply is "in flight" for W edges after acceptance, result is a*b.
    bit          m_valid = 0;
    bit          m_run   = 0;
    bit          m_done  = 0;
    int          m_rem   = 0;
    logic [63:0] m_pend  = '0;
    logic [63:0] m_prod  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1;
            m_run   = 0;
            m_done  = 0;
            m_rem   = 0;
            m_prod  = '0;
        end else if (m_run) begin
            m_rem--;
            if (m_rem == 0) begin
                m_run  = 0;
                m_done = 1;
                m_prod = m_pend;
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_run  = 1;
                m_rem  = W;
                m_pend = 64'(a) * 64'(b);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("mdl_busy", 64'(busy), 64'(m_run));
            chk("mdl_done", 64'(done), 64'(m_done));
            chk("mdl_product", 64'(product), 64'(m_prod[W-1:0]));
`ifdef ALU_MULT_HI_EN
            chk("mdl_product_hi", 64'(product_hi), 64'(m_prod[2*W-1:W]));
`endif
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            step();
        end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic clear_counts();
        busy_seen = 0;
        done_seen = 0;
    endtask

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", 64'(product), 64'd0);

        // Single multiply 3*5.
        clear_counts();
        launch(32'd3, 32'd5);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        wait_done();
        chk("t1_product", 64'(product), 64'd15);
`ifdef ALU_MULT_HI_EN
        chk("t1_product_hi", 64'(product_hi), 64'd0);
`endif
        chk("t1_busy_cycles", 64'(busy_seen), 64'd32);
        step();
        chk("t1_done_pulses", 64'(done_seen), 64'd1);
        chk("t1_done_one_cycle", 64'(done), 64'd0);

        // Hold: inputs wander, no start; product must not move.
        for (int i = 0; i < 50; i++) begin
            a = W'($urandom());
            b = W'($urandom());
            step();
            chk("hold_product", 64'(product), 64'd15);
            chk("hold_done", 64'(done), 64'd0);
        end

        // Max operands.
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        chk("max_product", 64'(product), 64'h1);
`ifdef ALU_MULT_HI_EN
        chk("max_product_hi", 64'(product_hi), 64'hFFFF_FFFE);
`endif
        step();

        // Start while busy is ignored.
        clear_counts();
        launch(32'd7, 32'd6);
        for (int i = 0; i < 9; i++) step();
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        chk("busy_ign_product", 64'(product), 64'd42);
        chk("busy_ign_timing", 64'(busy_seen), 64'd32);
        for (int i = 0; i < 40; i++) step();
        chk("busy_ign_single_done", 64'(done_seen), 64'd1);

        // Back-to-back: start held through the done cycle.
        clear_counts();
        a = 32'd2;
        b = 32'd3;
        start = 1'b1;
        step();
        a = 32'd4;
        b = 32'd4;
        wait_done();
        chk("b2b_first_product", 64'(product), 64'd6);
        step();
        start = 1'b0;
        chk("b2b_restart_busy", 64'(busy), 64'd1);
        chk("b2b_restart_done", 64'(done), 64'd0);
        wait_done();
        chk("b2b_second_product", 64'(product), 64'd16);
        chk("b2b_busy_cycles", 64'(busy_seen), 64'd64);
        step();
        chk("b2b_done_pulses", 64'(done_seen), 64'd2);

        // Reset mid-run aborts without a done pulse.
        clear_counts();
        launch(32'd100, 32'd200);
        for (int i = 0; i < 4; i++) step();
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_product", 64'(product), 64'd0);
        for (int i = 0; i < 40; i++) step();
        chk("rst_mid_no_done", 64'(done_seen), 64'd0);

        // Start coincident with reset is ignored.
        a = 32'd5;
        b = 32'd5;
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        step();
        chk("rst_start_busy2", 64'(busy), 64'd0);
        chk("rst_start_product", 64'(product), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard ceiling so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/alu_mult_seq.md
ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and product-half width in bits.
REQ-002 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request: capture operands and begin a multiply.
REQ-006 a  input  WIDTH  multiplicand, unsigned.
REQ-007 b  input  WIDTH  multiplier, unsigned.
REQ-008 busy  output  1  high while an accepted multiply is iterating.
REQ-009 done  output  1  one-cycle pulse: product valid and updated this cycle.
REQ-010 product  output  WIDTH  low half of a*b; drives the per-bit mult input (select 111) of the ALU result mux.
REQ-011 product_hi  output  WIDTH  high half of a*b; present only with ALU_MULT_HI_EN (REQ-026).

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE, encoded in 2 bits.
REQ-013 IDLE/DONE with start=1 SHALL capture a and b, clear the 2*WIDTH accumulator, clear the bit counter and go to RUN; IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-014 RUN SHALL process one multiplier bit per edge, radix-2 shift-add: if the current multiplier LSB=1, add the multiplicand shifted by the counter to the accumulator; then shift the multiplier right and increment the counter.
REQ-015 After exactly WIDTH RUN edges, the FSM SHALL go to DONE and register product = accumulator[WIDTH-1:0] (and product_hi = accumulator[2*WIDTH-1:WIDTH]) on that same edge.
REQ-016 Latency: start sampled at edge N gives busy=1 for cycles N..N+WIDTH-1 and done=1 for the single cycle after edge N+WIDTH.
REQ-017 busy SHALL be 1 iff state=RUN; done SHALL be 1 iff state=DONE.
REQ-018 start while in RUN SHALL be ignored: no operand capture and no restart.
REQ-019 start in DONE SHALL be accepted (back-to-back); done remains a one-cycle pulse.
REQ-020 product and product_hi SHALL change only on the RUN->DONE edge and SHALL hold otherwise, including through IDLE and a new RUN.
REQ-021 Arithmetic SHALL be unsigned, and the full 2*WIDTH product SHALL be exact with no overflow or truncation inside the accumulator.
REQ-022 Changes to a or b after capture SHALL NOT affect the in-flight result.

Reset
REQ-023 reset=1 at a rising edge SHALL force state=IDLE, busy=0, done=0, product=0, product_hi=0 and the counter, accumulator and operand registers to 0.
REQ-024 Reset SHALL take priority over start and SHALL abort any in-flight multiply with no done pulse.
REQ-025 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro ALU_MULT_HI_EN: when defined, port product_hi SHALL exist per REQ-011/015/020. When undefined, product_hi SHALL be absent, the accumulator SHALL be WIDTH bits wide, and product SHALL be unchanged.

Verification
REQ-027 Single multiply: a=3, b=5, start for 1 cycle -> busy for 32 cycles, then done=1 for 1 cycle with product=15, product_hi=0.
REQ-028 Max operands: a=b=0xFFFFFFFF -> product=0x00000001; with ALU_MULT_HI_EN, product_hi=0xFFFFFFFE.
REQ-029 Ignore while busy: start a=7,b=6; at busy cycle 10 pulse start with a=9,b=9 -> single done, product=42, done at original timing.
REQ-030 Reset mid-run: start a=100,b=200; reset at busy cycle 5 -> next cycle busy=0, done=0, product=0; no done pulse follows.
REQ-031 Back-to-back: start held through the done cycle of a=2,b=3 (result 6) with a=4,b=4 presented -> second run begins immediately, second done gives product=16.
REQ-032 Hold: after product=15, idle 50 cycles with a, b toggling randomly -> product stays 15 and done stays 0.
